rle_capture_ctrl: RTL and testbench

Capture sequencer that sits between the trigger logic, the run-length encoder and the sample-buffer write port. It arms on a host start command, waits for a trigger, and holds the encoder in reset outside the capture window. During capture it selects the word to write (encoder output or raw samples), counts written words against a configured depth, flags dropped words when the buffer back-pressures, and reports completion.

---
 rtl/rle_capture_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_rle_capture_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_capture_ctrl.sv
// ---------------------------------------------------------------------------
// rle_capture_ctrl
//
// Capture sequencer between the trigger logic, the run-length encoder and the
// sample-buffer write port. A host start command arms a capture. The first
// trigger starts the capture window. The window closes on a host stop or once
// the configured number of words has been accepted. Outside the capture window
// the encoder is held in reset.
//
// Ports
//   core_clk      : single clock for all logic
//   core_rst      : synchronous, active-high reset
//   cfg_start     : one-cycle start pulse; arms a capture (IDLE/DONE only)
//   cfg_stop      : one-cycle abort pulse (ARMED/RUN only)
//   cfg_rle_en    : 1 = write encoder words, 0 = write raw samples
//   cfg_depth     : words per capture, 0 = unlimited
//   trig_hit      : trigger level, qualified only in ARMED
//   sample_en     : raw-sample strobe (raw mode)
//   capture_data  : raw sample word
//   rle_data      : encoder word
//   rle_valid     : encoder word strobe (RLE mode)
//   rle_rst       : encoder reset, low only in RUN
//   wr_data       : buffer write word (0 when no word is written)
//   wr_valid      : buffer write strobe
//   wr_ready      : buffer can accept, sampled with the source strobe
//   busy          : high in ARMED and RUN
//   done          : high in DONE
//   overflow      : sticky, a word was dropped in the current capture
//   wr_count      : words accepted in the current capture
//   state_dbg     : current FSM state (0 IDLE, 1 ARMED, 2 RUN, 3 DONE)
//
// Write handshake: the buffer port is push-only. A source word in RUN is
// accepted when wr_ready is high in the same cycle as the strobe. An accepted
// word appears on wr_data with a one-cycle wr_valid pulse in the next cycle,
// and it is never held or retried. A word whose strobe sees wr_ready low is
// dropped and recorded in overflow.
// ---------------------------------------------------------------------------
module rle_capture_ctrl #(
   parameter int DEPTH_W = 32
) (
   input  logic               core_clk,
   input  logic               core_rst,
   input  logic               cfg_start,
   input  logic               cfg_stop,
   input  logic               cfg_rle_en,
   input  logic [DEPTH_W-1:0] cfg_depth,
   input  logic               trig_hit,
   input  logic               sample_en,
   input  logic [15:0]        capture_data,
   input  logic [15:0]        rle_data,
   input  logic               rle_valid,
   output logic               rle_rst,
   output logic [15:0]        wr_data,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic               busy,
   output logic               done,
   output logic               overflow,
   output logic [DEPTH_W-1:0] wr_count,
   output logic [1:0]         state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t             state_q;
   state_t             state_d;

   // Capture configuration, latched on an accepted start.
   logic               rle_en_q;
   logic [DEPTH_W-1:0] depth_q;

   logic [DEPTH_W-1:0] count_q;
   logic               ovf_q;
   logic               wr_valid_q;
   logic [15:0]        wr_data_q;

   // Datapath decode
   logic               start_ok;
   logic               src_strobe;
   logic [15:0]        src_word;
   logic               accept;
   logic               drop;
   logic [DEPTH_W-1:0] count_inc;
   logic               count_sat;
   logic               depth_hit;

   // A start is honoured only when no capture is in progress.
   assign start_ok = cfg_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   // Source strobes exist only inside the capture window. This also covers the
   // stop cycle: RUN is still the current state when cfg_stop arrives, so that
   // cycle's word is handled. Every later word falls into DONE and is ignored.
   assign src_strobe = (state_q == ST_RUN) && (rle_en_q ? rle_valid : sample_en);
   assign src_word   = rle_en_q ? rle_data : capture_data;
   assign accept     = src_strobe && wr_ready;
   assign drop       = src_strobe && !wr_ready;

   assign count_inc  = count_q + DEPTH_W'(1);
   assign count_sat  = &count_q;

   // With a nonzero depth the count never passes depth, so saturation does not
   // interfere with this compare. Saturation only matters for unlimited captures.
   assign depth_hit  = accept && (depth_q != '0) && (count_inc == depth_q);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            // A stop in the trigger cycle wins, so RUN is never entered.
            if (cfg_stop) begin
               state_d = ST_DONE;
            end else if (trig_hit) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cfg_stop || depth_hit) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (cfg_start) begin
               state_d = ST_ARMED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Latched capture configuration
   // ------------------------------------------------------------------
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         rle_en_q <= 1'b0;
         depth_q  <= '0;
      end else if (start_ok) begin
         rle_en_q <= cfg_rle_en;
         depth_q  <= cfg_depth;
      end
   end

   // ------------------------------------------------------------------
   // Word counter and sticky overflow. A start and a source strobe are
   // never active together, because they belong to disjoint states.
   // ------------------------------------------------------------------
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else if (start_ok) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (accept && !count_sat) begin
            count_q <= count_inc;
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Write port register: one-cycle latency. Data is forced to zero when
   // no word is written, so an idle bus reads 0.
   // ------------------------------------------------------------------
   always_ff @(posedge core_clk) begin
      if (core_rst) begin
         wr_valid_q <= 1'b0;
         wr_data_q  <= '0;
      end else begin
         wr_valid_q <= accept;
         wr_data_q  <= accept ? src_word : 16'h0000;
      end
   end

   // ------------------------------------------------------------------
   // Outputs are decoded only from registers.
   // ------------------------------------------------------------------
   assign rle_rst   = (state_q != ST_RUN);
   assign busy      = (state_q == ST_ARMED) || (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign overflow  = ovf_q;
   assign wr_count  = count_q;
   assign wr_valid  = wr_valid_q;
   assign wr_data   = wr_data_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_rle_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rle_capture_ctrl
//
// Directed testbench for rle_capture_ctrl. Inputs are driven 1 time unit after
// each rising edge. Outputs are sampled at the same point, so each check sees
// the registers updated by the edge that has just passed.
// ---------------------------------------------------------------------------
module tb_rle_capture_ctrl;

   localparam int DEPTH_W = 32;

   // Status vector {state_dbg, busy, done, rle_rst, overflow}
   localparam logic [5:0] S_IDLE  = 6'b00_0_0_1_0;
   localparam logic [5:0] S_ARMED = 6'b01_1_0_1_0;
   localparam logic [5:0] S_RUN0  = 6'b10_1_0_0_0;
   localparam logic [5:0] S_RUN1  = 6'b10_1_0_0_1;
   localparam logic [5:0] S_DONE0 = 6'b11_0_1_1_0;
   localparam logic [5:0] S_DONE1 = 6'b11_0_1_1_1;

   logic               core_clk;
   logic               core_rst;
   logic               cfg_start;
   logic               cfg_stop;
   logic               cfg_rle_en;
   logic [DEPTH_W-1:0] cfg_depth;
   logic               trig_hit;
   logic               sample_en;
   logic [15:0]        capture_data;
   logic [15:0]        rle_data;
   logic               rle_valid;
   logic               rle_rst;
   logic [15:0]        wr_data;
   logic               wr_valid;
   logic               wr_ready;
   logic               busy;
   logic               done;
   logic               overflow;
   logic [DEPTH_W-1:0] wr_count;
   logic [1:0]         state_dbg;

   logic [5:0]         st;
   assign st = {state_dbg, busy, done, rle_rst, overflow};

   int passed = 0;
   int total  = 0;

   rle_capture_ctrl #(.DEPTH_W(DEPTH_W)) dut (
      .core_clk     (core_clk),
      .core_rst     (core_rst),
      .cfg_start    (cfg_start),
      .cfg_stop     (cfg_stop),
      .cfg_rle_en   (cfg_rle_en),
      .cfg_depth    (cfg_depth),
      .trig_hit     (trig_hit),
      .sample_en    (sample_en),
      .capture_data (capture_data),
      .rle_data     (rle_data),
      .rle_valid    (rle_valid),
      .rle_rst      (rle_rst),
      .wr_data      (wr_data),
      .wr_valid     (wr_valid),
      .wr_ready     (wr_ready),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .wr_count     (wr_count),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock ----------------
   initial begin
      core_clk = 1'b0;
      forever #5 core_clk = ~core_clk;
   end

   // ---------------- drivers ----------------
   task automatic tick;
      @(posedge core_clk);
      #1;
   endtask

   task automatic drive_idle;
      core_rst     = 1'b0;
      cfg_start    = 1'b0;
      cfg_stop     = 1'b0;
      cfg_rle_en   = 1'b0;
      cfg_depth    = '0;
      trig_hit     = 1'b0;
      sample_en    = 1'b0;
      capture_data = 16'h0000;
      rle_data     = 16'h0000;
      rle_valid    = 1'b0;
      wr_ready     = 1'b1;
   endtask

   task automatic do_start(input logic rle_en, input logic [DEPTH_W-1:0] depth);
      cfg_rle_en = rle_en;
      cfg_depth  = depth;
      cfg_start  = 1'b1;
      tick();
      cfg_start  = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      core_rst = 1'b1;
      tick();
      tick();
      total++;
      if (st !== S_IDLE) $display("FAIL reset_status: got %b expected %b", st, S_IDLE);
      else passed++;
      total++;
      if ({wr_valid, wr_data, wr_count} !== 49'd0)
         $display("FAIL reset_write: got valid=%b data=%h count=%0d expected 0/0/0", wr_valid, wr_data, wr_count);
      else passed++;
      core_rst = 1'b0;
      tick();
      total++;
      if (st !== S_IDLE) $display("FAIL reset_release: got %b expected %b", st, S_IDLE);
      else passed++;
   endtask

   task automatic test_raw_depth;
      logic [7:0]  vld;
      logic [15:0] dat [8];
      logic [5:0]  st3;
      logic [DEPTH_W-1:0] cnt3;
      do_start(1'b0, 32'd4);
      total++;
      if (st !== S_ARMED) $display("FAIL raw_armed: got %b expected %b", st, S_ARMED);
      else passed++;
      // Trigger cycle: a sample is present but the state is still ARMED.
      sample_en    = 1'b1;
      capture_data = 16'h0001;
      trig_hit     = 1'b1;
      tick();
      trig_hit = 1'b0;
      total++;
      if ({st, wr_valid} !== {S_RUN0, 1'b0})
         $display("FAIL raw_run_entry: got st=%b valid=%b expected st=%b valid=0", st, wr_valid, S_RUN0);
      else passed++;
      st3  = '0;
      cnt3 = '0;
      for (int i = 0; i < 8; i++) begin
         capture_data = 16'(i + 2);
         tick();
         vld[i] = wr_valid;
         dat[i] = wr_data;
         if (i == 3) begin
            st3  = st;
            cnt3 = wr_count;
         end
      end
      sample_en = 1'b0;
      total++;
      if (vld !== 8'b0000_1111) $display("FAIL raw_valid_pattern: got %b expected %b", vld, 8'b0000_1111);
      else passed++;
      for (int k = 0; k < 4; k++) begin
         total++;
         if (dat[k] !== 16'(k + 2)) $display("FAIL raw_word%0d: got %h expected %h", k, dat[k], 16'(k + 2));
         else passed++;
      end
      total++;
      if ({dat[4], dat[5], dat[6], dat[7]} !== 64'd0)
         $display("FAIL raw_idle_data: got %h %h %h %h expected 0", dat[4], dat[5], dat[6], dat[7]);
      else passed++;
      total++;
      if ({st3, cnt3} !== {S_DONE0, 32'd4})
         $display("FAIL raw_done_with_last: got st=%b count=%0d expected st=%b count=4", st3, cnt3, S_DONE0);
      else passed++;
      total++;
      if ({st, wr_count} !== {S_DONE0, 32'd4})
         $display("FAIL raw_final: got st=%b count=%0d expected st=%b count=4", st, wr_count, S_DONE0);
      else passed++;
   endtask

   task automatic test_rle_stop;
      do_start(1'b1, 32'd0);
      total++;
      if ({st, wr_count} !== {S_ARMED, 32'd0})
         $display("FAIL rle_armed: got st=%b count=%0d expected st=%b count=0", st, wr_count, S_ARMED);
      else passed++;
      // Encoder words in ARMED are ignored.
      rle_valid = 1'b1;
      rle_data  = 16'h7777;
      tick();
      rle_valid = 1'b0;
      total++;
      if ({st, wr_valid} !== {S_ARMED, 1'b0})
         $display("FAIL rle_armed_ignore: got st=%b valid=%b expected st=%b valid=0", st, wr_valid, S_ARMED);
      else passed++;
      trig_hit = 1'b1;
      tick();
      trig_hit = 1'b0;
      total++;
      if (st !== S_RUN0) $display("FAIL rle_run: got %b expected %b", st, S_RUN0);
      else passed++;
      rle_valid = 1'b1;
      rle_data  = 16'h0012;
      tick();
      total++;
      if ({wr_valid, wr_data, wr_count} !== {1'b1, 16'h0012, 32'd1})
         $display("FAIL rle_word0: got valid=%b data=%h count=%0d expected 1/0012/1", wr_valid, wr_data, wr_count);
      else passed++;
      rle_data = 16'h8005;
      tick();
      total++;
      if ({wr_valid, wr_data, wr_count} !== {1'b1, 16'h8005, 32'd2})
         $display("FAIL rle_word1: got valid=%b data=%h count=%0d expected 1/8005/2", wr_valid, wr_data, wr_count);
      else passed++;
      // Raw strobes are ignored in RLE mode.
      rle_valid    = 1'b0;
      sample_en    = 1'b1;
      capture_data = 16'hffff;
      tick();
      sample_en = 1'b0;
      total++;
      if ({st, wr_valid, wr_data} !== {S_RUN0, 1'b0, 16'h0000})
         $display("FAIL rle_gap: got st=%b valid=%b data=%h expected st=%b 0/0000", st, wr_valid, wr_data, S_RUN0);
      else passed++;
      cfg_stop = 1'b1;
      tick();
      cfg_stop = 1'b0;
      total++;
      if ({st, wr_count} !== {S_DONE0, 32'd2})
         $display("FAIL rle_stop_done: got st=%b count=%0d expected st=%b count=2", st, wr_count, S_DONE0);
      else passed++;
   endtask

   task automatic test_backpressure;
      logic [4:0]  vld;
      logic [4:0]  ovf;
      logic [15:0] dat [5];
      logic [DEPTH_W-1:0] cnt [5];
      logic [15:0] exp_dat [5];
      logic [DEPTH_W-1:0] exp_cnt [5];
      exp_dat = '{16'h00a1, 16'h0000, 16'h00a3, 16'h00a4, 16'h0000};
      exp_cnt = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd3};
      do_start(1'b0, 32'd3);
      total++;
      if ({st, wr_count} !== {S_ARMED, 32'd0})
         $display("FAIL bp_armed: got st=%b count=%0d expected st=%b count=0", st, wr_count, S_ARMED);
      else passed++;
      trig_hit = 1'b1;
      tick();
      trig_hit = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample_en    = 1'b1;
         capture_data = 16'(16'h00a1 + i);
         wr_ready     = (i != 1);
         tick();
         vld[i] = wr_valid;
         ovf[i] = overflow;
         dat[i] = wr_data;
         cnt[i] = wr_count;
      end
      sample_en = 1'b0;
      wr_ready  = 1'b1;
      total++;
      if (vld !== 5'b01101) $display("FAIL bp_valid_pattern: got %b expected %b", vld, 5'b01101);
      else passed++;
      total++;
      if (ovf !== 5'b11110) $display("FAIL bp_overflow_pattern: got %b expected %b", ovf, 5'b11110);
      else passed++;
      for (int k = 0; k < 5; k++) begin
         total++;
         if ({dat[k], cnt[k]} !== {exp_dat[k], exp_cnt[k]})
            $display("FAIL bp_cycle%0d: got data=%h count=%0d expected data=%h count=%0d",
                     k, dat[k], cnt[k], exp_dat[k], exp_cnt[k]);
         else passed++;
      end
      total++;
      if (st !== S_DONE1) $display("FAIL bp_final: got %b expected %b", st, S_DONE1);
      else passed++;
   endtask

   task automatic test_collisions;
      // Start from DONE clears overflow and count.
      do_start(1'b1, 32'd0);
      total++;
      if ({st, wr_count} !== {S_ARMED, 32'd0})
         $display("FAIL col_restart_clear: got st=%b count=%0d expected st=%b count=0", st, wr_count, S_ARMED);
      else passed++;
      // Trigger and stop together in ARMED.
      trig_hit = 1'b1;
      cfg_stop = 1'b1;
      tick();
      trig_hit = 1'b0;
      cfg_stop = 1'b0;
      total++;
      if (st !== S_DONE0) $display("FAIL col_trig_stop: got %b expected %b", st, S_DONE0);
      else passed++;
      tick();
      total++;
      if (st !== S_DONE0) $display("FAIL col_trig_stop_hold: got %b expected %b", st, S_DONE0);
      else passed++;
      // Start and stop together in DONE: start wins.
      cfg_rle_en = 1'b0;
      cfg_start  = 1'b1;
      cfg_stop   = 1'b1;
      tick();
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      total++;
      if (st !== S_ARMED) $display("FAIL col_start_stop_done: got %b expected %b", st, S_ARMED);
      else passed++;
      trig_hit = 1'b1;
      tick();
      trig_hit = 1'b0;
      // Lone start in RUN is ignored.
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      total++;
      if (st !== S_RUN0) $display("FAIL col_start_in_run: got %b expected %b", st, S_RUN0);
      else passed++;
      // Start and stop together in RUN: stop wins, no re-arm.
      cfg_start = 1'b1;
      cfg_stop  = 1'b1;
      tick();
      cfg_start = 1'b0;
      cfg_stop  = 1'b0;
      total++;
      if (st !== S_DONE0) $display("FAIL col_start_stop_run: got %b expected %b", st, S_DONE0);
      else passed++;
      tick();
      total++;
      if (st !== S_DONE0) $display("FAIL col_no_rearm: got %b expected %b", st, S_DONE0);
      else passed++;
   endtask

   task automatic test_reset_mid_run;
      do_start(1'b0, 32'd0);
      trig_hit = 1'b1;
      tick();
      trig_hit = 1'b0;
      sample_en    = 1'b1;
      capture_data = 16'h0055;
      wr_ready     = 1'b0;
      tick();
      total++;
      if ({st, wr_valid} !== {S_RUN1, 1'b0})
         $display("FAIL mid_drop: got st=%b valid=%b expected st=%b valid=0", st, wr_valid, S_RUN1);
      else passed++;
      wr_ready     = 1'b1;
      capture_data = 16'h0066;
      tick();
      total++;
      if ({wr_valid, wr_data, wr_count} !== {1'b1, 16'h0066, 32'd1})
         $display("FAIL mid_write: got valid=%b data=%h count=%0d expected 1/0066/1", wr_valid, wr_data, wr_count);
      else passed++;
      // Another word is being accepted in the reset cycle.
      capture_data = 16'h0077;
      core_rst     = 1'b1;
      tick();
      core_rst  = 1'b0;
      sample_en = 1'b0;
      total++;
      if (st !== S_IDLE) $display("FAIL mid_reset_status: got %b expected %b", st, S_IDLE);
      else passed++;
      total++;
      if ({wr_valid, wr_data, wr_count} !== 49'd0)
         $display("FAIL mid_reset_write: got valid=%b data=%h count=%0d expected 0/0/0", wr_valid, wr_data, wr_count);
      else passed++;
      cfg_stop = 1'b1;
      tick();
      cfg_stop = 1'b0;
      total++;
      if (st !== S_IDLE) $display("FAIL idle_stop_ignored: got %b expected %b", st, S_IDLE);
      else passed++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      drive_idle();
      test_reset();
      test_raw_depth();
      test_rle_stop();
      test_backpressure();
      test_collisions();
      test_reset_mid_run();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
